rom_arb_sp: RTL and testbench
=============================

# rom_arb_sp

Two-port arbiter and sequencer for the generic single-port ROM: it shares one synchronous read port between two independent requesters, such as the palette lookup and the coordinate-table reader. It issues at most one ROM read per enabled clock and tracks which requester owns each in-flight read. It returns registered data to that requester with a one-cycle valid pulse. It sits directly between the requesters and the ROM's `rd`/`adr`/`dat_r` pins and shares the ROM's `clk_en`.

## Interface
- `DW`, 8: data width; must equal the ROM data width.
- `AW`, 10: address width; must equal the ROM address width.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `clk_en`  in  1  clock enable; also drives the ROM's `clk_en`.
- `req0` / `req1`  in  1  read request, port 0 / 1.
- `adr0` / `adr1`  in  AW  read address, port 0 / 1.
- `gnt0` / `gnt1`  out  1  request accepted this cycle; combinational.
- `vld0` / `vld1`  out  1  read data valid pulse, port 0 / 1.
- `dat0` / `dat1`  out  DW  read data, port 0 / 1; registered.
- `rom_rd`  out  1  ROM read enable; combinational.
- `rom_adr`  out  AW  ROM address; combinational.
- `rom_dat_r`  in  DW  ROM read data; valid one enabled cycle after `rom_rd`.

## Operation
- Handshake:
  - A requester holds `reqN` high and `adrN` stable until it sees `gntN` high at a rising edge where `clk_en` is high.
  - The read is accepted at that edge.
  - `reqN` may stay high for back-to-back reads; each granted cycle is one read.
- Grant:
  - `gnt0` and `gnt1` are mutually exclusive.
  - Both are 0 whenever `clk_en` is 0.
  - A single requester is granted every enabled cycle, giving full throughput.
- Arbitration:
  - Round-robin on a 1-bit pointer `lst` holding the last granted port.
  - When both ports request, the port that is not `lst` wins.
  - `lst` updates on every grant.
  - Reset value of `lst` is 1, so port 0 wins the first conflict.
- ROM drive:
  - `rom_rd = gnt0 | gnt1`.
  - `rom_adr = gnt1 ? adr1 : adr0`; when idle it defaults to `adr0`.
- Tag pipeline:
  - On each enabled edge, register `tag_v = rom_rd` and `tag_p = gnt1`.
  - On the next enabled edge, if `tag_v` is set, capture `rom_dat_r` into `dat[tag_p]` and set `vld[tag_p]` for that cycle.
  - The other port's `dat` holds its previous value.
- Output hold: `datN` holds its last captured value until the next read completes for port N.
- Reset values:
  - `vld0 = vld1 = 0`, `dat0 = dat1 = 0`.
  - `tag_v = 0`, `lst = 1`.
  - `gnt*` and `rom_rd` are 0 while `rst` is high.
- Reset mid-operation: any in-flight read is discarded and no `vld` pulse appears for it after reset is released.

## Timing
- Latency: grant at enabled edge E → `vldN` high during the cycle after enabled edge E+1, i.e. 2 enabled cycles. `datN` is valid in that same cycle.
- `vldN` is a registered flag, output-gated by `clk_en`, so it is high for exactly one enabled cycle per read.
- Stalls:
  - When `clk_en` is low, all state (`lst`, tag, `dat`, `vld` register) holds.
  - The ROM also holds its output while `clk_en` is low, so no data is lost.
- Sustained throughput: one read per enabled cycle; with both ports requesting continuously, grants alternate 0,1,0,1….
- Simultaneous events: a capture for one port and a new grant to either port in the same cycle are independent and both occur.
- Grant ordering equals completion ordering; there is no reordering.

## Configuration
- Macro `ROM_ARB_PRIO_EN`.
- Defined: fixed priority.
  - Port 0 always wins a conflict; port 1 is granted only when `req0` is low.
  - `lst` is not implemented.
- Undefined (default): round-robin as described in Operation.
- Latency, handshake and reset behaviour are identical in both builds.

## Test plan
- Single read: `req0=1`, `adr0=0x005` held until `gnt0`. Required: `gnt0` at edge 0, `rom_adr=0x005`, `vld0` after edge 1, `dat0=mem[5]`, `vld1` never asserted.
- Conflict, round-robin: `req0` and `req1` both held for 4 enabled cycles with `adr0=0x010`, `adr1=0x020`. Required: grants 0,1,0,1; `vld` pulses alternate 0,1,0,1 two cycles later with `mem[0x10]`/`mem[0x20]`. With `ROM_ARB_PRIO_EN` defined: grants 0,0,0,0 and `vld1` never asserted.
- Stall: grant port 1 (`adr1=0x3FF`), then drop `clk_en` for 3 cycles after the grant edge. Required: no `vld1` while `clk_en` is low; `vld1` is a single-cycle pulse with `dat1=mem[0x3FF]` on the second enabled cycle.
- Back-to-back with hold: port 0 reads `0x001` then `0x002` consecutively. Required: two consecutive `vld0` pulses; `dat1` keeps its prior value throughout.
- Reset mid-flight: assert `rst` asynchronously one cycle after `gnt0`. Required: immediately `vld0=0` and `dat0=0`; no `vld` after release; the first post-reset conflict is granted to port 0.

Source files
------------

// File: rtl/rom_arb_sp.sv
// rom_arb_sp: shares one synchronous single-port ROM read port between two
// requesters. At most one ROM read is issued per enabled clock. A one-bit
// tag pipeline records the owner of each in-flight read, and the returned
// data is handed back to that owner with a single-cycle valid pulse.
//
// Build option: define ROM_ARB_PRIO_EN to use fixed priority, where port 0
// always wins a conflict. By default the macro is undefined and a
// round-robin pointer alternates the winner between conflicting requests.
module rom_arb_sp #(
  parameter int DW = 8,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en_i,
  input  logic          req0_i,
  input  logic          req1_i,
  input  logic [AW-1:0] adr0_i,
  input  logic [AW-1:0] adr1_i,
  output logic          gnt0_o,
  output logic          gnt1_o,
  output logic          vld0_o,
  output logic          vld1_o,
  output logic [DW-1:0] dat0_o,
  output logic [DW-1:0] dat1_o,
  output logic          rom_rd_o,
  output logic [AW-1:0] rom_adr_o,
  input  logic [DW-1:0] rom_dat_r_i
);

  logic          pick1;
  logic          gnt0;
  logic          gnt1;
  logic          romRd;
  logic          tagV_q, tagV_d;
  logic          tagP_q, tagP_d;
  logic          vld0_q, vld0_d;
  logic          vld1_q, vld1_d;
  logic [DW-1:0] dat0_q, dat0_d;
  logic [DW-1:0] dat1_q, dat1_d;
`ifndef ROM_ARB_PRIO_EN
  logic          lst_q, lst_d;
`endif

  // Arbitration: decide the winner and gate grants off during reset or a stall
  always_comb begin
`ifdef ROM_ARB_PRIO_EN
    pick1 = req1_i & ~req0_i;
`else
    pick1 = req1_i & (~req0_i | ~lst_q);
`endif
    gnt1  = ~rst & clk_en_i & pick1;
    gnt0  = ~rst & clk_en_i & req0_i & ~pick1;
    romRd = gnt0 | gnt1;
  end

  assign gnt0_o    = gnt0;
  assign gnt1_o    = gnt1;
  assign rom_rd_o  = romRd;
  assign rom_adr_o = gnt1 ? adr1_i : adr0_i;
  assign vld0_o    = vld0_q & clk_en_i;
  assign vld1_o    = vld1_q & clk_en_i;
  assign dat0_o    = dat0_q;
  assign dat1_o    = dat1_q;

  // Next state: on an enabled cycle, advance the tag and capture returning data for its owner
  always_comb begin
    tagV_d = tagV_q;
    tagP_d = tagP_q;
    vld0_d = vld0_q;
    vld1_d = vld1_q;
    dat0_d = dat0_q;
    dat1_d = dat1_q;
`ifndef ROM_ARB_PRIO_EN
    lst_d  = lst_q;
`endif
    if (clk_en_i) begin
      tagV_d = romRd;
      tagP_d = gnt1;
      vld0_d = tagV_q & ~tagP_q;
      vld1_d = tagV_q & tagP_q;
      if (tagV_q & ~tagP_q) dat0_d = rom_dat_r_i;
      if (tagV_q & tagP_q)  dat1_d = rom_dat_r_i;
`ifndef ROM_ARB_PRIO_EN
      if (romRd) lst_d = gnt1;
`endif
    end
  end

  // State registers; reset discards any in-flight read and clears the outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tagV_q <= 1'b0;
      tagP_q <= 1'b0;
      vld0_q <= 1'b0;
      vld1_q <= 1'b0;
      dat0_q <= '0;
      dat1_q <= '0;
`ifndef ROM_ARB_PRIO_EN
      lst_q  <= 1'b1;
`endif
    end else begin
      tagV_q <= tagV_d;
      tagP_q <= tagP_d;
      vld0_q <= vld0_d;
      vld1_q <= vld1_d;
      dat0_q <= dat0_d;
      dat1_q <= dat1_d;
`ifndef ROM_ARB_PRIO_EN
      lst_q  <= lst_d;
`endif
    end
  end

endmodule

// File: tb/tb_rom_arb_sp.sv
// Testbench for rom_arb_sp: a ROM model, a queue-based reference model
// compared on every negative edge, and directed scenarios with literal
// expectations.
module tb_rom_arb_sp;
  localparam int DW = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clk_en = 1'b0;
  logic          req0 = 1'b0;
  logic          req1 = 1'b0;
  logic [AW-1:0] adr0 = '0;
  logic [AW-1:0] adr1 = '0;
  logic          gnt0, gnt1, vld0, vld1, rom_rd;
  logic [DW-1:0] dat0, dat1;
  logic [AW-1:0] rom_adr;
  logic [DW-1:0] romDat = '0;
  logic [DW-1:0] mem [1<<AW];

  int testsRun = 0;
  int failCount = 0;
  bit chkEn = 1'b0;

  rom_arb_sp #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .clk_en_i(clk_en),
    .req0_i(req0), .req1_i(req1), .adr0_i(adr0), .adr1_i(adr1),
    .gnt0_o(gnt0), .gnt1_o(gnt1), .vld0_o(vld0), .vld1_o(vld1),
    .dat0_o(dat0), .dat1_o(dat1), .rom_rd_o(rom_rd), .rom_adr_o(rom_adr),
    .rom_dat_r_i(romDat)
  );

  always #5 clk = ~clk;

  // ROM contents: low byte of 3*addr + 17
  function automatic logic [DW-1:0] romVal(input int a);
    return DW'(a * 3 + 17);
  endfunction

  initial for (int i = 0; i < (1 << AW); i++) mem[i] = romVal(i);

  // Synchronous ROM: reads on an enabled edge, holds otherwise
  always @(posedge clk) if (clk_en && rom_rd) romDat <= mem[rom_adr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: completion queue indexed by enabled-cycle count
  typedef struct { int port; int addr; int due; } rd_t;
  rd_t pend[$];
  logic [DW-1:0] mDat [2];
  int mLast = 1;
  int enCycle = 0;
  int win;
  int ev0, ev1;
  logic [AW-1:0] expAdr;

  always @(negedge clk) if (chkEn) begin
    if (rst) begin
      pend.delete();
      mDat[0] = '0; mDat[1] = '0; mLast = 1;
      check("rst_gnt0", 32'(gnt0), 0);
      check("rst_gnt1", 32'(gnt1), 0);
      check("rst_rom_rd", 32'(rom_rd), 0);
      check("rst_vld0", 32'(vld0), 0);
      check("rst_vld1", 32'(vld1), 0);
      check("rst_dat0", 32'(dat0), 0);
      check("rst_dat1", 32'(dat1), 0);
    end else begin
      win = -1;
      if (clk_en) begin
        if (req0 && req1) begin
`ifdef ROM_ARB_PRIO_EN
          win = 0;
`else
          win = 1 - mLast;
`endif
        end else if (req0) win = 0;
        else if (req1) win = 1;
      end
      ev0 = 0; ev1 = 0;
      if (pend.size() > 0 && pend[0].due <= enCycle) begin
        mDat[pend[0].port] = romVal(pend[0].addr);
        if (clk_en) begin
          if (pend[0].port == 0) ev0 = 1; else ev1 = 1;
        end
      end
      expAdr = (win == 1) ? adr1 : adr0;
      check("gnt0", 32'(gnt0), 32'(win == 0));
      check("gnt1", 32'(gnt1), 32'(win == 1));
      check("rom_rd", 32'(rom_rd), 32'(win >= 0));
      check("rom_adr", 32'(rom_adr), 32'(expAdr));
      check("vld0", 32'(vld0), 32'(ev0));
      check("vld1", 32'(vld1), 32'(ev1));
      check("dat0", 32'(dat0), 32'(mDat[0]));
      check("dat1", 32'(dat1), 32'(mDat[1]));
      if (clk_en) begin
        if (pend.size() > 0 && pend[0].due <= enCycle) void'(pend.pop_front());
        if (win >= 0) begin
          pend.push_back('{win, int'(expAdr), enCycle + 2});
          mLast = win;
        end
        enCycle++;
      end
    end
  end

  // Samples of the DUT outputs taken mid-cycle by the stimulus tasks
  logic sG0, sG1, sV0, sV1;
  logic [DW-1:0] sD0, sD1;
  logic [AW-1:0] sAdr;

  task automatic applyStimulus();
    @(negedge clk);
    sG0 = gnt0; sG1 = gnt1; sV0 = vld0; sV1 = vld1;
    sD0 = dat0; sD1 = dat1; sAdr = rom_adr;
    @(posedge clk);
    #1;
  endtask

  task automatic waitGrant(input int port, output int cycles);
    cycles = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus();
      if ((port == 0 && sG0) || (port == 1 && sG1)) begin
        cycles = i + 1;
        break;
      end
    end
    check($sformatf("grant_port%0d_seen", port), 32'(cycles > 0), 1);
  endtask

  int cyc, firstIdx, cnt;
  logic [DW-1:0] firstDat;
  int gSeq[$];
  int vSeq[$];
  logic [DW-1:0] vDat[$];
  int expPort[4];
  logic [DW-1:0] expDat[4];

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Reset with a pending request: grants must stay low
    #2 rst = 1'b1;
    chkEn = 1'b1;
    clk_en = 1'b1;
    req0 = 1'b1; adr0 = 10'h005;
    repeat (3) applyStimulus();
    check("reset_gnt0", 32'(sG0), 0);
    check("reset_vld0", 32'(sV0), 0);
    check("reset_dat0", 32'(sD0), 0);
    rst = 1'b0;

    // Single read from port 0
    waitGrant(0, cyc);
    check("single_rom_adr", 32'(sAdr), 32'h005);
    req0 = 1'b0;
    firstIdx = -1; cnt = 0; firstDat = '0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus();
      if (sV0 && firstIdx < 0) begin firstIdx = i; firstDat = sD0; end
      if (sV1) cnt++;
    end
    check("single_vld0_cycle", 32'(firstIdx), 1);
    check("single_dat0", 32'(firstDat), 32'h20);
    check("single_no_vld1", 32'(cnt), 0);

    // Port 1 read followed by a three-cycle stall
    req1 = 1'b1; adr1 = 10'h3FF;
    waitGrant(1, cyc);
    req1 = 1'b0;
    clk_en = 1'b0;
    cnt = 0;
    repeat (3) begin
      applyStimulus();
      if (sV1) cnt++;
    end
    check("stall_no_vld1", 32'(cnt), 0);
    clk_en = 1'b1;
    firstIdx = -1; cnt = 0; firstDat = '0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      if (sV1) begin
        cnt++;
        if (firstIdx < 0) begin firstIdx = i; firstDat = sD1; end
      end
    end
    check("stall_vld1_cycle", 32'(firstIdx), 1);
    check("stall_vld1_count", 32'(cnt), 1);
    check("stall_dat1", 32'(firstDat), 32'h0E);

    // Back-to-back reads on port 0; port 1 data must hold
    req0 = 1'b1; adr0 = 10'h001;
    waitGrant(0, cyc);
    adr0 = 10'h002;
    waitGrant(0, cyc);
    check("b2b_second_immediate", 32'(cyc), 1);
    req0 = 1'b0;
    vDat.delete(); firstIdx = -1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus();
      if (sV0) begin
        if (firstIdx < 0) firstIdx = i;
        vDat.push_back(sD0);
      end
      check("b2b_dat1_hold", 32'(sD1), 32'h0E);
    end
    check("b2b_vld0_first", 32'(firstIdx), 0);
    check("b2b_vld0_count", 32'(vDat.size()), 2);
    if (vDat.size() == 2) begin
      check("b2b_dat_a", 32'(vDat[0]), 32'h14);
      check("b2b_dat_b", 32'(vDat[1]), 32'h17);
    end

    // Reset while a read is completing
    req0 = 1'b1; adr0 = 10'h005;
    waitGrant(0, cyc);
    req0 = 1'b0;
    applyStimulus();
    check("prerst_vld0", 32'(vld0), 1);
    rst = 1'b1;
    #1;
    check("midrst_vld0", 32'(vld0), 0);
    check("midrst_dat0", 32'(dat0), 0);
    repeat (2) applyStimulus();
    rst = 1'b0;
    cnt = 0;
    repeat (4) begin
      applyStimulus();
      if (sV0 || sV1) cnt++;
    end
    check("postrst_no_vld", 32'(cnt), 0);

    // Conflict: both ports request for four enabled cycles
`ifdef ROM_ARB_PRIO_EN
    expPort = '{0, 0, 0, 0};
    expDat  = '{8'h41, 8'h41, 8'h41, 8'h41};
`else
    expPort = '{0, 1, 0, 1};
    expDat  = '{8'h41, 8'h71, 8'h41, 8'h71};
`endif
    req0 = 1'b1; adr0 = 10'h010;
    req1 = 1'b1; adr1 = 10'h020;
    gSeq.delete(); vSeq.delete(); vDat.delete();
    for (int i = 0; i < 8; i++) begin
      applyStimulus();
      if (sG0) gSeq.push_back(0);
      if (sG1) gSeq.push_back(1);
      if (sV0) begin vSeq.push_back(0); vDat.push_back(sD0); end
      if (sV1) begin vSeq.push_back(1); vDat.push_back(sD1); end
      if (i == 3) begin req0 = 1'b0; req1 = 1'b0; end
    end
    check("conflict_grant_count", 32'(gSeq.size()), 4);
    check("conflict_vld_count", 32'(vSeq.size()), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < gSeq.size()) check($sformatf("conflict_grant%0d", i), 32'(gSeq[i]), 32'(expPort[i]));
      if (i < vSeq.size()) begin
        check($sformatf("conflict_vld_port%0d", i), 32'(vSeq[i]), 32'(expPort[i]));
        check($sformatf("conflict_vld_dat%0d", i), 32'(vDat[i]), 32'(expDat[i]));
      end
    end

    chkEn = 1'b0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
